// File: rtl/aes_encrypt_iter_ctrl_pkg.sv
// Shared types, sizing helpers and AES byte/word primitives for the iterative encryptor.
// The S-box is derived from the GF(2^8) inverse plus the affine map, so no lookup table is stored.
package aes_pkg;

  localparam int ROUND_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int nr_for(input int n);
    return (n == 256) ? 14 : (n == 192) ? 12 : 10;
  endfunction

  function automatic int nk_for(input int n);
    return n / 32;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); zero maps to zero
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r    = 8'h01;
    base = x;
    e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox(w[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] addRoundKey(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_ctrl_if.sv
// Job-in / ciphertext-out handshake bundle between a producer/consumer and the controller.
interface aes_encrypt_iter_ctrl_if #(parameter int N = 128) ();
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [N-1:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (output in_valid, in_data, in_key, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, in_key, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_encrypt_iter_ctrl_round_core.sv
// One combinational AES round; the last round skips MixColumns.
module aes_round_core
  import aes_pkg::*;
(
  input  logic [127:0] in,
  input  logic [127:0] rk,
  input  logic         final_rnd,
  output logic [127:0] out
);

  logic [127:0] sr;

  assign sr  = shiftRows(subBytes(in));
  assign out = addRoundKey(final_rnd ? sr : mixColumns(sr), rk);

endmodule

// File: rtl/keyExpansion.sv
// Full AES key schedule; round key r occupies keySched[W-1-128*r -: 128].
module keyExpansion
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic [N-1:0]          key,
  output logic [128*(Nr+1)-1:0] keySched
);

  localparam int WORDS = 4 * (Nr + 1);

  function automatic logic [128*(Nr+1)-1:0] expand(input logic [N-1:0] k);
    logic [31:0]           w [WORDS];
    logic [31:0]           t;
    logic [7:0]            rc;
    logic [128*(Nr+1)-1:0] s;
    rc = 8'h01;
    s  = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (i < Nk) begin
        w[i] = k[N-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % Nk == 0) begin
          t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = subWord(t);
        end
        w[i] = w[i-Nk] ^ t;
      end
      s[128*(Nr+1)-1-32*i -: 32] = w[i];
    end
    return s;
  endfunction

  assign keySched = expand(key);

endmodule

// File: rtl/aes_encrypt_iter_ctrl.sv
// Iterative AES encryptor: one shared round core stepped Nr times per block.
//   state | meaning
//   IDLE  | waiting for a plaintext/key job, in_ready=1
//   ROUND | applying round round_idx to state_q
//   DONE  | ciphertext held on out_data until out_ready
module aes_encrypt_iter_ctrl
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = nr_for(N),
  parameter int Nk = nk_for(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_encrypt_iter_ctrl_if.slave bus,
  output logic                   busy,
  output logic [ROUND_IDX_W-1:0] round_idx
);

  localparam int                     SCHED_W = 128 * (Nr + 1);
  localparam logic [ROUND_IDX_W-1:0] NR_L    = ROUND_IDX_W'(Nr);

  state_e                 state, state_d;
  logic [127:0]           state_q, state_nx;
  logic [N-1:0]           key_q, key_d;
  logic [ROUND_IDX_W-1:0] ridx_d;
  logic [127:0]           od_q, od_d;
  logic                   ov_q, ov_d;
  logic [SCHED_W-1:0]     key_sched;
  logic [127:0]           rk_tab [Nr+1];
  logic [127:0]           core_out;
  logic                   is_last;
  logic                   accept;

  keyExpansion #(.N(N), .Nr(Nr), .Nk(Nk)) u_kexp (
    .key      (key_q),
    .keySched (key_sched)
  );

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rk_tab[r] = key_sched[SCHED_W-1-128*r -: 128];
  end

  assign is_last = (round_idx == NR_L);

  aes_round_core u_core (
    .in        (state_q),
    .rk        (rk_tab[round_idx]),
    .final_rnd (is_last),
    .out       (core_out)
  );

  // DONE can hand over directly to a new job when the consumer takes the result
  assign bus.in_ready  = !rst && (state == IDLE || (state == DONE && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign busy          = (state != IDLE);

  always_comb begin
    state_d  = state;
    state_nx = state_q;
    key_d    = key_q;
    ridx_d   = round_idx;
    od_d     = od_q;
    ov_d     = ov_q;
    case (state)
      IDLE: ;
      ROUND: begin
        if (is_last) begin
          od_d    = core_out;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          state_nx = core_out;
          ridx_d   = round_idx + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          ridx_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_nx = bus.in_data ^ bus.in_key[N-1 -: 128];
      key_d    = bus.in_key;
      ridx_d   = 4'd1;
      state_d  = ROUND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      round_idx <= '0;
      od_q      <= '0;
      ov_q      <= 1'b0;
    end else begin
      state     <= state_d;
      state_q   <= state_nx;
      key_q     <= key_d;
      round_idx <= ridx_d;
      od_q      <= od_d;
      ov_q      <= ov_d;
    end
  end

endmodule
